alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//   Initiator side of the ALU interface: accepts RV32I OP/OP-IMM instruction words, decodes them,
//   reads rs1/rs2 from the external register file, and drives funct3 plus operands into alu_base.
//   One clock later it collects the registered ALU result and writes it back to rd.
//   Sits between fetch and alu_base/register file. Non-pipelined: one instruction in flight.
// PARAMETERS
//   XLEN        32  data width of operands, result and instruction word
//   REG_ADDR_W  5   register file address width
// PORTS
//   clock          in   1        single system clock, all state on posedge
//   reset          in   1        synchronous, active-high
//   instr_valid    in   1        instr_word holds an instruction
//   instr_word     in   XLEN     RV32I instruction
//   instr_ready    out  1        block is IDLE and accepts an instruction
//   rs1_addr       out  REG_ADDR_W  register file read address 1
//   rs2_addr       out  REG_ADDR_W  register file read address 2
//   rs1_data       in   XLEN     combinational read data for rs1_addr
//   rs2_data       in   XLEN     combinational read data for rs2_addr
//   alu_enable     out  1        high while operands to alu_base are valid
//   alu_funct3     out  3        operation select to alu_base
//   alu_operand_1  out  XLEN     to register_data_1
//   alu_operand_2  out  XLEN     to register_data_2
//   alu_result     in   XLEN     registered register_data_out from alu_base
//   rd_we          out  1        one-cycle register file write strobe
//   rd_addr        out  REG_ADDR_W  write address
//   rd_data        out  XLEN     write data
//   illegal_instr  out  1        one-cycle pulse: instruction rejected
// BEHAVIOUR
//   Reset: state=IDLE; instr_ready=1; every other output 0. Reset in any state aborts with no write.
//   FSM: IDLE -> ISSUE -> EXECUTE -> WRITEBACK -> IDLE; IDLE -> REJECT -> IDLE.
//   IDLE: instr_ready=1. Handshake = instr_valid & instr_ready: latch instr_word, decode.
//     Legal: ->ISSUE. Illegal: ->REJECT. No handshake: stay.
//   ISSUE: rs1_addr=instr[19:15], rs2_addr=instr[24:20]. At the closing edge, register alu_funct3,
//     alu_operand_1=rs1_data, alu_operand_2=(OP ? rs2_data : sext(instr[31:20])), and set alu_enable=1.
//   EXECUTE: operands held stable. alu_base samples them on the closing edge.
//   WRITEBACK: rd_we=1, rd_addr=instr[11:7], rd_data=alu_result, alu_enable=0. rd==0: rd_we held 0.
//   REJECT: illegal_instr=1 for exactly one cycle, no ALU activity, no write.
//   Latency: handshake on edge N gives rd_we high in cycle N+3 and instr_ready high again in N+4.
//     Throughput: 1 instruction / 4 cycles.
//   Legal set:
//     opcode 0110011 (OP) with funct7==0000000;
//     opcode 0010011 (OP-IMM), where funct3 001/101 also require instr[31:25]==0000000.
//     All else is illegal, including SUB/SRA (funct7=0100000), which alu_base lacks.
//   Shifts (funct3 001/101): alu_operand_2 zero-extended from bits [4:0] only, upper 27 bits 0.
//   SLT/SLTU: funct3 passed through unchanged; comparison semantics belong to alu_base.
//   instr_word is sampled only on handshake; changes at any other time are ignored.
// STRUCTURE
//   Package rv32_alu_pkg:
//     opcode constants (OPC_OP, OPC_OP_IMM); funct3 constants ADD..AND;
//     FSM state encoding (3-bit: IDLE, ISSUE, EXECUTE, WRITEBACK, REJECT).
//   Sub-module rv32_alu_decode (combinational):
//     instr -> {legal, is_imm, funct3, rs1, rs2, rd, imm_sext}.
//   Top holds the FSM and the output registers.
// TESTING
//   1 ADDI x1,x0,5 (0x00500093), rs1_data=0, alu_result=5
//       -> funct3=0, op2=0x5; rd_we cycle N+3, rd_addr=1, rd_data=5.
//   2 ADDI x2,x0,-1 (0xFFF00113) -> alu_operand_2=0xFFFFFFFF.
//   3 SLL x3,x1,x2 (0x002091B3), rs2_data=0xFFFFFFE3
//       -> alu_funct3=1, alu_operand_2=0x3.
//   4 SUB (0x40208233) -> illegal_instr one pulse N+1, rd_we never asserted, instr_ready back N+2.
//   5 ADD to x0 (0x00208033) -> full FSM sequence, rd_we stays 0.
//   6 reset asserted during EXECUTE -> next cycle IDLE, all outputs 0, no write.
//     instr_valid held high with no handshake while busy -> second instr accepted only at N+4.

Source files
------------

// File: rtl/rv32_alu_pkg.sv
// Shared definitions for the RV32I ALU issue controller.
//   - Major opcodes handled by alu_base (OP, OP-IMM)
//   - funct3 operation encodings ADD..AND
//   - Issue FSM state encoding
//   - is_shift_op(): funct3 values whose second operand is a 5-bit shift amount
package rv32_alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    // Only the base funct7 is implemented; SUB/SRA variants are rejected.
    localparam logic [6:0] F7_BASE    = 7'b0000000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_REJECT    = 3'd4
    } issue_state_e;

    function automatic logic is_shift_op(input logic [2:0] f3);
        return (f3 == F3_SLL) || (f3 == F3_SRL);
    endfunction

endpackage

// File: rtl/rv32_alu_decode.sv
// Combinational decoder for RV32I OP / OP-IMM instruction words.
// Ports:
//   instr_i     in   XLEN        instruction word
//   legal_o     out  1           instruction is supported by alu_base
//   is_imm_o    out  1           OP-IMM form (second operand from immediate)
//   funct3_o    out  3           operation select
//   rs1_o       out  REG_ADDR_W  source register 1
//   rs2_o       out  REG_ADDR_W  source register 2
//   rd_o        out  REG_ADDR_W  destination register
//   imm_sext_o  out  XLEN        sign-extended I-type immediate
module rv32_alu_decode
    import rv32_alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [XLEN-1:0]        instr_i,
    output logic                   legal_o,
    output logic                   is_imm_o,
    output logic [2:0]             funct3_o,
    output logic [REG_ADDR_W-1:0]  rs1_o,
    output logic [REG_ADDR_W-1:0]  rs2_o,
    output logic [REG_ADDR_W-1:0]  rd_o,
    output logic signed [XLEN-1:0] imm_sext_o
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       is_op;

    assign opcode   = instr_i[6:0];
    assign funct7   = instr_i[31:25];
    assign funct3_o = instr_i[14:12];
    assign rd_o     = instr_i[7 +: REG_ADDR_W];
    assign rs1_o    = instr_i[15 +: REG_ADDR_W];
    assign rs2_o    = instr_i[20 +: REG_ADDR_W];

    assign is_op    = (opcode == OPC_OP);
    assign is_imm_o = (opcode == OPC_OP_IMM);

    assign imm_sext_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};

    // Register-register ops need the base funct7 (no SUB/SRA). Immediate
    // shifts encode funct7 in the upper immediate bits, so only they are
    // constrained; all other OP-IMM forms use the full 12-bit immediate.
    assign legal_o = (is_op && (funct7 == F7_BASE)) ||
                     (is_imm_o && (!is_shift_op(funct3_o) || (funct7 == F7_BASE)));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller driving alu_base: accepts one RV32I OP/OP-IMM instruction
// at a time, reads its operands from the register file, presents them to the
// ALU, and writes the registered ALU result back to rd.
// Sequence: IDLE -> ISSUE -> EXECUTE -> WRITEBACK -> IDLE, or IDLE -> REJECT -> IDLE.
// Ports:
//   clock, reset              clock and synchronous active-high reset
//   instr_valid/instr_word    instruction offer from fetch
//   instr_ready               high in IDLE; handshake = valid & ready
//   rs1_addr/rs2_addr         register file read addresses (driven in ISSUE)
//   rs1_data/rs2_data         combinational register file read data
//   alu_enable                operands valid to alu_base (EXECUTE)
//   alu_funct3                operation select to alu_base
//   alu_operand_1/_2          operands to alu_base
//   alu_result                registered result from alu_base
//   rd_we/rd_addr/rd_data     register file write port (WRITEBACK)
//   illegal_instr             one-cycle pulse for a rejected instruction
module alu_issue_ctrl
    import rv32_alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic [XLEN-1:0]       instr_word,
    output logic                  instr_ready,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    output logic                  alu_enable,
    output logic [2:0]            alu_funct3,
    output logic [XLEN-1:0]       alu_operand_1,
    output logic [XLEN-1:0]       alu_operand_2,
    input  logic [XLEN-1:0]       alu_result,
    output logic                  rd_we,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd_data,
    output logic                  illegal_instr
);

    issue_state_e          state_q;
    logic [XLEN-1:0]       instr_q;
    logic                  instr_ready_q;
    logic [REG_ADDR_W-1:0] rs1_addr_q;
    logic [REG_ADDR_W-1:0] rs2_addr_q;
    logic                  alu_enable_q;
    logic [2:0]            alu_funct3_q;
    logic [XLEN-1:0]       alu_op1_q;
    logic [XLEN-1:0]       alu_op2_q;
    logic                  rd_we_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic                  illegal_q;

    logic                  dec_legal;
    logic                  dec_is_imm;
    logic [2:0]            dec_funct3;
    logic [REG_ADDR_W-1:0] dec_rs1;
    logic [REG_ADDR_W-1:0] dec_rs2;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic signed [XLEN-1:0] dec_imm;
    logic [XLEN-1:0]       dec_instr;

    logic [XLEN-1:0]       op2_raw;
    logic [XLEN-1:0]       op2_d;

    // One decoder serves both phases: in IDLE it classifies the offered
    // word for the accept/reject decision, afterwards it decodes the
    // latched copy so later changes on instr_word cannot leak in.
    assign dec_instr = (state_q == ST_IDLE) ? instr_word : instr_q;

    rv32_alu_decode #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_decode (
        .instr_i    (dec_instr),
        .legal_o    (dec_legal),
        .is_imm_o   (dec_is_imm),
        .funct3_o   (dec_funct3),
        .rs1_o      (dec_rs1),
        .rs2_o      (dec_rs2),
        .rd_o       (dec_rd),
        .imm_sext_o (dec_imm)
    );

    // Shift amounts use only the low five bits of either source.
    always_comb begin
        op2_raw = dec_is_imm ? dec_imm : rs2_data;
        op2_d   = op2_raw;
        if (is_shift_op(dec_funct3)) begin
            op2_d = {{(XLEN-5){1'b0}}, op2_raw[4:0]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            instr_ready_q <= 1'b1;
            rs1_addr_q    <= '0;
            rs2_addr_q    <= '0;
            alu_enable_q  <= 1'b0;
            alu_funct3_q  <= '0;
            alu_op1_q     <= '0;
            alu_op2_q     <= '0;
            rd_we_q       <= 1'b0;
            rd_addr_q     <= '0;
            illegal_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid && instr_ready_q) begin
                        instr_q       <= instr_word;
                        instr_ready_q <= 1'b0;
                        if (dec_legal) begin
                            state_q    <= ST_ISSUE;
                            rs1_addr_q <= dec_rs1;
                            rs2_addr_q <= dec_rs2;
                        end else begin
                            state_q   <= ST_REJECT;
                            illegal_q <= 1'b1;
                        end
                    end
                end
                // ---- ISSUE -> EXECUTE: capture register file data as operands
                ST_ISSUE: begin
                    state_q      <= ST_EXECUTE;
                    rs1_addr_q   <= '0;
                    rs2_addr_q   <= '0;
                    alu_enable_q <= 1'b1;
                    alu_funct3_q <= dec_funct3;
                    alu_op1_q    <= rs1_data;
                    alu_op2_q    <= op2_d;
                end
                // ---- EXECUTE -> WRITEBACK: alu_base samples operands on this edge
                ST_EXECUTE: begin
                    state_q      <= ST_WRITEBACK;
                    alu_enable_q <= 1'b0;
                    alu_funct3_q <= '0;
                    alu_op1_q    <= '0;
                    alu_op2_q    <= '0;
                    // x0 is hardwired zero: run the op but suppress the write.
                    rd_we_q      <= (dec_rd != '0);
                    rd_addr_q    <= dec_rd;
                end
                ST_WRITEBACK: begin
                    state_q       <= ST_IDLE;
                    rd_we_q       <= 1'b0;
                    rd_addr_q     <= '0;
                    instr_ready_q <= 1'b1;
                end
                ST_REJECT: begin
                    state_q       <= ST_IDLE;
                    illegal_q     <= 1'b0;
                    instr_ready_q <= 1'b1;
                end
                default: begin
                    state_q       <= ST_IDLE;
                    instr_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready   = instr_ready_q;
    assign rs1_addr      = rs1_addr_q;
    assign rs2_addr      = rs2_addr_q;
    assign alu_enable    = alu_enable_q;
    assign alu_funct3    = alu_funct3_q;
    assign alu_operand_1 = alu_op1_q;
    assign alu_operand_2 = alu_op2_q;
    assign rd_we         = rd_we_q;
    assign rd_addr       = rd_addr_q;
    assign illegal_instr = illegal_q;

    // alu_result is already registered inside alu_base and only becomes
    // valid in WRITEBACK, so it is forwarded rather than re-registered.
    assign rd_data = (state_q == ST_WRITEBACK) ? alu_result : '0;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid;
    logic [31:0] instr_word;
    logic        instr_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        alu_enable;
    logic [2:0]  alu_funct3;
    logic [31:0] alu_operand_1;
    logic [31:0] alu_operand_2;
    logic [31:0] alu_result = '0;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        illegal_instr;

    always #5 clock = ~clock;

    alu_issue_ctrl #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_word    (instr_word),
        .instr_ready   (instr_ready),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .alu_enable    (alu_enable),
        .alu_funct3    (alu_funct3),
        .alu_operand_1 (alu_operand_1),
        .alu_operand_2 (alu_operand_2),
        .alu_result    (alu_result),
        .rd_we         (rd_we),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .illegal_instr (illegal_instr)
    );

    // Static register file contents (x0 = 0, x2 chosen for the SLL case).
    logic [31:0] regs [32];
    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;     // number of rising edges seen so far
    bit chk_on   = 0;

    function automatic logic [31:0] alu_f(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // Stand-in for alu_base: result registered one edge after sampling operands.
    always_ff @(posedge clock) begin
        if (alu_enable) alu_result <= alu_f(alu_funct3, alu_operand_1, alu_operand_2);
    end

    function automatic bit f_legal(input logic [31:0] w);
        if (w[6:0] == 7'b0110011) return (w[31:25] == 7'd0);
        if (w[6:0] == 7'b0010011) begin
            if (w[14:12] == 3'd1 || w[14:12] == 3'd5) return (w[31:25] == 7'd0);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] f_op2(input logic [31:0] w);
        logic [31:0] v;
        if (w[6:0] == 7'b0110011) v = regs[w[24:20]];
        else                      v = {{20{w[31]}}, w[31:20]};
        if (w[14:12] == 3'd1 || w[14:12] == 3'd5) v = v & 32'h1F;
        return v;
    endfunction

    // Transaction-level model: remembers the accepting edge and what that
    // instruction must produce; output timing follows from the elapsed edges.
    int          m_acc   = -100;
    bit          m_legal = 0;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [2:0]  m_f3;
    logic [31:0] m_op1, m_op2, m_res;

    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                m_acc = -100;
            end else if (instr_valid && ((cyc - m_acc) >= (m_legal ? 3 : 1))) begin
                m_legal = f_legal(instr_word);
                m_rs1   = instr_word[19:15];
                m_rs2   = instr_word[24:20];
                m_rd    = instr_word[11:7];
                m_f3    = instr_word[14:12];
                m_op1   = regs[instr_word[19:15]];
                m_op2   = f_op2(instr_word);
                m_res   = alu_f(m_f3, m_op1, m_op2);
                m_acc   = cyc + 1;
            end
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    int         d;
    logic       e_ready, e_ill, e_en, e_we;
    logic [4:0] e_rs1, e_rs2, e_rd;
    initial begin
        forever begin
            @(negedge clock);
            if (chk_on) begin
                d = cyc - m_acc;
                e_ready = 1'b1; e_ill = 1'b0; e_en = 1'b0; e_we = 1'b0;
                e_rs1 = '0; e_rs2 = '0; e_rd = '0;
                if (m_legal) begin
                    if (d == 0) begin e_ready = 1'b0; e_rs1 = m_rs1; e_rs2 = m_rs2; end
                    if (d == 1) begin e_ready = 1'b0; e_en = 1'b1; end
                    if (d == 2) begin e_ready = 1'b0; e_we = (m_rd != 5'd0); e_rd = m_rd; end
                end else if (d == 0) begin
                    e_ready = 1'b0; e_ill = 1'b1;
                end
                chk("instr_ready", 32'(instr_ready), 32'(e_ready));
                chk("illegal_instr", 32'(illegal_instr), 32'(e_ill));
                chk("rs1_addr", 32'(rs1_addr), 32'(e_rs1));
                chk("rs2_addr", 32'(rs2_addr), 32'(e_rs2));
                chk("alu_enable", 32'(alu_enable), 32'(e_en));
                chk("rd_we", 32'(rd_we), 32'(e_we));
                chk("rd_addr", 32'(rd_addr), 32'(e_rd));
                if (e_en) begin
                    chk("alu_funct3", 32'(alu_funct3), 32'(m_f3));
                    chk("alu_operand_1", alu_operand_1, m_op1);
                    chk("alu_operand_2", alu_operand_2, m_op2);
                end
                if (e_we) chk("rd_data", rd_data, m_res);
            end
        end
    end

    // Offer w until accepted; n returns the edge index of the handshake.
    task automatic send(input logic [31:0] w, input bit keep, output int n);
        instr_valid = 1'b1;
        instr_word  = w;
        n = -1;
        for (int i = 0; i < 16; i++) begin
            if (instr_ready === 1'b1) begin
                n = cyc + 1;
                break;
            end
            @(negedge clock);
        end
        if (n < 0) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: instr_ready never high for %h", w);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        if (!keep) begin
            instr_valid = 1'b0;
            instr_word  = $urandom;
        end
    endtask

    // Move to the negedge inside the cycle that ends with edge c.
    task automatic goto(input int c);
        while (cyc < c - 1) @(negedge clock);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [2:0]  f3;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: begin
                f3 = 3'($urandom_range(0, 7));
                if (f3 == 3'd1 || f3 == 3'd5) f3 = 3'd0;
                w[14:12] = f3; w[6:0] = 7'b0010011;
            end
            1: begin
                w[14:12] = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
                w[6:0] = 7'b0010011;
                if ($urandom_range(0, 2) != 0) w[31:25] = 7'd0;
            end
            2: begin w[31:25] = 7'd0; w[6:0] = 7'b0110011; end
            3: begin w[31:25] = 7'b0100000; w[6:0] = 7'b0110011; end
            4: ;
            default: begin
                w[6:0] = ($urandom_range(0, 1) == 0) ? 7'b0110011 : 7'b0010011;
            end
        endcase
        return w;
    endfunction

    int n, na, nb;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'd0;
        regs[2] = 32'hFFFFFFE3;
        instr_valid = 1'b0;
        instr_word  = 32'd0;
        reset       = 1'b1;

        repeat (2) @(negedge clock);
        chk("reset_instr_ready", 32'(instr_ready), 32'd1);
        chk("reset_alu_enable", 32'(alu_enable), 32'd0);
        chk("reset_rd_we", 32'(rd_we), 32'd0);
        chk("reset_illegal", 32'(illegal_instr), 32'd0);
        chk("reset_operand_1", alu_operand_1, 32'd0);
        chk("reset_rs1_addr", 32'(rs1_addr), 32'd0);
        chk_on = 1;
        #1 reset = 1'b0;

        // ADDI x1,x0,5
        send(32'h00500093, 1'b0, n);
        goto(n + 2);
        chk("addi_enable", 32'(alu_enable), 32'd1);
        chk("addi_funct3", 32'(alu_funct3), 32'd0);
        chk("addi_op2", alu_operand_2, 32'h5);
        goto(n + 3);
        chk("addi_rd_we", 32'(rd_we), 32'd1);
        chk("addi_rd_addr", 32'(rd_addr), 32'd1);
        chk("addi_rd_data", rd_data, 32'd5);
        goto(n + 4);
        chk("addi_ready_back", 32'(instr_ready), 32'd1);

        // ADDI x2,x0,-1
        send(32'hFFF00113, 1'b0, n);
        goto(n + 2);
        chk("addi_neg_op2", alu_operand_2, 32'hFFFFFFFF);

        // SLL x3,x1,x2 with x2 = 0xFFFFFFE3
        send(32'h002091B3, 1'b0, n);
        goto(n + 2);
        chk("sll_funct3", 32'(alu_funct3), 32'd1);
        chk("sll_op2", alu_operand_2, 32'h3);

        // SUB is rejected
        send(32'h40208233, 1'b0, n);
        goto(n + 1);
        chk("sub_illegal", 32'(illegal_instr), 32'd1);
        chk("sub_ready_low", 32'(instr_ready), 32'd0);
        chk("sub_no_we", 32'(rd_we), 32'd0);
        goto(n + 2);
        chk("sub_illegal_off", 32'(illegal_instr), 32'd0);
        chk("sub_ready_back", 32'(instr_ready), 32'd1);

        // ADD x0,x1,x2: full sequence, no write
        send(32'h00208033, 1'b0, n);
        goto(n + 1);
        chk("add_x0_rs1", 32'(rs1_addr), 32'd1);
        chk("add_x0_rs2", 32'(rs2_addr), 32'd2);
        goto(n + 2);
        chk("add_x0_enable", 32'(alu_enable), 32'd1);
        goto(n + 3);
        chk("add_x0_no_we", 32'(rd_we), 32'd0);
        goto(n + 4);
        chk("add_x0_ready", 32'(instr_ready), 32'd1);

        // Reset during EXECUTE aborts without a write
        send(32'h00500093, 1'b0, n);
        goto(n + 2);
        reset = 1'b1;
        goto(n + 3);
        chk("abort_ready", 32'(instr_ready), 32'd1);
        chk("abort_enable", 32'(alu_enable), 32'd0);
        chk("abort_rd_we", 32'(rd_we), 32'd0);
        chk("abort_rd_data", rd_data, 32'd0);
        chk("abort_operand_2", alu_operand_2, 32'd0);
        #1 reset = 1'b0;

        // Valid held high while busy: next accept four edges later
        send(32'h00500093, 1'b1, na);
        send(32'h002091B3, 1'b0, nb);
        chk("accept_gap", 32'(nb - na), 32'd4);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 250; k++) begin
            send(rand_instr(), 1'b0, n);
            repeat ($urandom_range(0, 4)) @(negedge clock);
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clock);
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
        end
        repeat (6) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "time limit reached");
    end

endmodule
